// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Handles multi-bubble load-use stalls, branch-in-ID operand hazards and the data-cache freeze.
module hazard_stall_ctrl #(
  parameter int REG_W     = 5,
  parameter int INSTR_W   = 32,
  parameter int RS_LSB    = 21,
  parameter int RT_LSB    = 16,
  parameter int LOAD_LAT  = 1,
  parameter int BRANCH_ID = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               IDEX_MemRead_i,
  input  logic               IDEX_RegWrite_i,
  input  logic [REG_W-1:0]   IDEX_RegisterRd_i,
  input  logic               EXMEM_MemRead_i,
  input  logic [REG_W-1:0]   EXMEM_RegisterRd_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               ID_Branch_i,
  input  logic               dcache_stall_i,
  output logic               PCStall_o,
  output logic               IFIDStall_o,
  output logic               IDEXBubble_o,
  output logic               PipeFreeze_o,
  output logic [CNT_W-1:0]   stall_cycles_o
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  localparam logic [2:0]       LU_INIT = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, next_state;
  logic [2:0]       bub_cnt, next_bub;
  logic [REG_W-1:0] rs, rt;
  logic             ex_match, mem_match;
  logic             load_use, branch_haz;
  logic             stall, bubble, freeze;
  logic             unused_instr_bits;

  assign rs = instr_i[RS_LSB +: REG_W];
  assign rt = instr_i[RT_LSB +: REG_W];
  assign unused_instr_bits = ^instr_i;

  // Register 0 is hardwired, so a write to it can never be a real dependency.
  assign ex_match  = (IDEX_RegisterRd_i != '0) &&
                     ((IDEX_RegisterRd_i == rs) || (IDEX_RegisterRd_i == rt));
  assign mem_match = (EXMEM_RegisterRd_i != '0) &&
                     ((EXMEM_RegisterRd_i == rs) || (EXMEM_RegisterRd_i == rt));

  assign load_use   = IDEX_MemRead_i && ex_match;
  assign branch_haz = (BRANCH_ID != 0) && ID_Branch_i &&
                      ((IDEX_RegWrite_i && ex_match) || (EXMEM_MemRead_i && mem_match));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      bub_cnt <= 3'd0;
    end else begin
      state   <= next_state;
      bub_cnt <= next_bub;
    end
  end

  // Freeze outranks everything and leaves the bubble count untouched.
  always_comb begin
    stall      = 1'b0;
    bubble     = 1'b0;
    freeze     = 1'b0;
    next_state = state;
    next_bub   = bub_cnt;
    if (dcache_stall_i) begin
      stall  = 1'b1;
      freeze = 1'b1;
    end else if (state == LU_STALL) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (bub_cnt == 3'd1) begin
        next_state = IDLE;
        next_bub   = 3'd0;
      end else begin
        next_bub = bub_cnt - 3'd1;
      end
    end else if (load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        next_state = LU_STALL;
        next_bub   = LU_INIT;
      end
    end else if (branch_haz) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  assign PCStall_o    = rst_i & stall;
  assign IFIDStall_o  = rst_i & stall;
  assign IDEXBubble_o = rst_i & bubble;
  assign PipeFreeze_o = rst_i & freeze;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_o <= '0;
    end else if (PCStall_o && (stall_cycles_o != CNT_MAX)) begin
      stall_cycles_o <= stall_cycles_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: four controller configurations share one stimulus stream and
// are checked each cycle against a behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;

  localparam int LAT [4] = '{1, 3, 1, 1};
  localparam int BR  [4] = '{1, 1, 0, 1};
  localparam int CW  [4] = '{16, 16, 16, 4};

  typedef struct packed {
    logic [3:0][3:0]  ctrl;
    logic [3:0][15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idex_mr, idex_rw, exmem_mr, id_branch, dcache_stall;
  logic [4:0]  idex_rd, exmem_rd;
  logic [31:0] instr;

  wire  [3:0]  pc_s, ifid_s, bub_s, frz_s;
  wire  [15:0] cnt_a, cnt_b, cnt_c;
  wire  [3:0]  cnt_d;

  exp_t sb [$];
  int   rem  [4];
  int   mcnt [4];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_LAT(1), .BRANCH_ID(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .IDEX_MemRead_i(idex_mr), .IDEX_RegWrite_i(idex_rw),
    .IDEX_RegisterRd_i(idex_rd), .EXMEM_MemRead_i(exmem_mr), .EXMEM_RegisterRd_i(exmem_rd),
    .instr_i(instr), .ID_Branch_i(id_branch), .dcache_stall_i(dcache_stall),
    .PCStall_o(pc_s[0]), .IFIDStall_o(ifid_s[0]), .IDEXBubble_o(bub_s[0]),
    .PipeFreeze_o(frz_s[0]), .stall_cycles_o(cnt_a));

  hazard_stall_ctrl #(.LOAD_LAT(3), .BRANCH_ID(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .IDEX_MemRead_i(idex_mr), .IDEX_RegWrite_i(idex_rw),
    .IDEX_RegisterRd_i(idex_rd), .EXMEM_MemRead_i(exmem_mr), .EXMEM_RegisterRd_i(exmem_rd),
    .instr_i(instr), .ID_Branch_i(id_branch), .dcache_stall_i(dcache_stall),
    .PCStall_o(pc_s[1]), .IFIDStall_o(ifid_s[1]), .IDEXBubble_o(bub_s[1]),
    .PipeFreeze_o(frz_s[1]), .stall_cycles_o(cnt_b));

  hazard_stall_ctrl #(.LOAD_LAT(1), .BRANCH_ID(0), .CNT_W(16)) dut_c (
    .clk_i(clk), .rst_i(rst_n), .IDEX_MemRead_i(idex_mr), .IDEX_RegWrite_i(idex_rw),
    .IDEX_RegisterRd_i(idex_rd), .EXMEM_MemRead_i(exmem_mr), .EXMEM_RegisterRd_i(exmem_rd),
    .instr_i(instr), .ID_Branch_i(id_branch), .dcache_stall_i(dcache_stall),
    .PCStall_o(pc_s[2]), .IFIDStall_o(ifid_s[2]), .IDEXBubble_o(bub_s[2]),
    .PipeFreeze_o(frz_s[2]), .stall_cycles_o(cnt_c));

  hazard_stall_ctrl #(.LOAD_LAT(1), .BRANCH_ID(1), .CNT_W(4)) dut_d (
    .clk_i(clk), .rst_i(rst_n), .IDEX_MemRead_i(idex_mr), .IDEX_RegWrite_i(idex_rw),
    .IDEX_RegisterRd_i(idex_rd), .EXMEM_MemRead_i(exmem_mr), .EXMEM_RegisterRd_i(exmem_rd),
    .instr_i(instr), .ID_Branch_i(id_branch), .dcache_stall_i(dcache_stall),
    .PCStall_o(pc_s[3]), .IFIDStall_o(ifid_s[3]), .IDEXBubble_o(bub_s[3]),
    .PipeFreeze_o(frz_s[3]), .stall_cycles_o(cnt_d));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int obsCnt(input int k);
    case (k)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      2:       return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  // Drive one cycle of inputs, predict every configuration's outputs and queue them.
  task automatic applyStimulus(input logic rst, input logic ld, input logic rw, input logic [4:0] rd,
                               input logic exld, input logic [4:0] exrd, input logic [4:0] rs,
                               input logic [4:0] rt, input logic br, input logic dst);
    exp_t e;
    logic lu, bh;
    @(posedge clk);
    #1;
    rst_n = rst; idex_mr = ld; idex_rw = rw; idex_rd = rd;
    exmem_mr = exld; exmem_rd = exrd; id_branch = br; dcache_stall = dst;
    instr = $urandom;
    instr[25:21] = rs;
    instr[20:16] = rt;
    lu = ld && (rd != 0) && (rd == rs || rd == rt);
    for (int k = 0; k < 4; k++) begin
      bh = (BR[k] == 1) && br && ((rw && rd != 0 && (rd == rs || rd == rt)) ||
                                  (exld && exrd != 0 && (exrd == rs || exrd == rt)));
      if (!rst) begin
        rem[k] = 0; mcnt[k] = 0; e.ctrl[k] = 4'b0000;
      end else if (dst) e.ctrl[k] = 4'b1101;
      else if (rem[k] > 0) begin e.ctrl[k] = 4'b1110; rem[k]--; end
      else if (lu) begin e.ctrl[k] = 4'b1110; rem[k] = LAT[k] - 1; end
      else if (bh) e.ctrl[k] = 4'b1110;
      else e.ctrl[k] = 4'b0000;
      e.cnt[k] = 16'(mcnt[k]);
      if (rst && e.ctrl[k][3] && mcnt[k] < (1 << CW[k]) - 1) mcnt[k]++;
    end
    sb.push_back(e);
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyIdle(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("ctrl_dut%0d", k), int'({pc_s[k], ifid_s[k], bub_s[k], frz_s[k]}),
                    int'(e.ctrl[k]));
        checkOutput($sformatf("cnt_dut%0d", k), obsCnt(k), int'(e.cnt[k]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; idex_mr = 0; idex_rw = 0; idex_rd = 0; exmem_mr = 0; exmem_rd = 0;
    instr = 0; id_branch = 0; dcache_stall = 0;
    for (int k = 0; k < 4; k++) begin rem[k] = 0; mcnt[k] = 0; end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 5, 1, 5, 5, 5, 1, 1);
    applyIdle(1);

    // load-use on rs
    applyStimulus(1, 1, 1, 5, 0, 0, 5, 3, 0, 0);
    applyIdle(4);
    @(negedge clk); #1;
    checkOutput("lu1_cnt", int'(cnt_a), 1);
    checkOutput("lu3_cnt_a", int'(cnt_b), 3);

    // register 0 never matches
    applyReset();
    applyStimulus(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    applyIdle(2);
    @(negedge clk); #1;
    checkOutput("r0_cnt", int'(cnt_a), 0);

    // load-use on rt, three bubbles
    applyReset();
    applyStimulus(1, 1, 1, 8, 0, 0, 2, 8, 0, 0);
    applyIdle(4);
    @(negedge clk); #1;
    checkOutput("lu3_cnt_b", int'(cnt_b), 3);

    // freeze for 4 cycles starting in the 2nd bubble
    applyReset();
    applyStimulus(1, 1, 1, 8, 0, 0, 2, 8, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyIdle(4);
    @(negedge clk); #1;
    checkOutput("frz_lu3_cnt", int'(cnt_b), 7);
    checkOutput("frz_lu1_cnt", int'(cnt_a), 5);

    // branch operand produced by the EX instruction
    applyReset();
    applyStimulus(1, 0, 1, 9, 0, 0, 9, 1, 1, 0);
    applyIdle(2);
    @(negedge clk); #1;
    checkOutput("br_cnt", int'(cnt_a), 1);
    checkOutput("br_off_cnt", int'(cnt_c), 0);

    // load followed by a dependent branch
    applyReset();
    applyStimulus(1, 1, 1, 9, 0, 0, 9, 2, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 9, 9, 2, 1, 0);
    applyIdle(3);
    @(negedge clk); #1;
    checkOutput("ldbr_cnt", int'(cnt_a), 2);
    checkOutput("ldbr_off_cnt", int'(cnt_c), 1);

    // counter saturation
    applyReset();
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyIdle(2);
    @(negedge clk); #1;
    checkOutput("sat_cnt4", int'(cnt_d), 15);
    checkOutput("sat_cnt16", int'(cnt_a), 20);

    // reset in the middle of a multi-bubble stall
    applyReset();
    applyStimulus(1, 1, 1, 8, 0, 0, 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyIdle(4);
    @(negedge clk); #1;
    checkOutput("midrst_cnt", int'(cnt_b), 0);

    // random traffic over a small register set
    for (int i = 0; i < 60; i++)
      applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) == 0));
    applyIdle(3);

    repeat (2) @(posedge clk);
    checkOutput("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
